// File: rtl/sig_a_pkg.sv
// Shared types and constants for the sig_A debouncer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package sig_a_pkg;

  // Debouncer FSM: each level has a resting state and a qualifying state.
  typedef enum logic [1:0] {
    IDLE_LOW   = 2'd0,
    CHECK_HIGH = 2'd1,
    IDLE_HIGH  = 2'd2,
    CHECK_LOW  = 2'd3
  } deb_state_t;

  localparam int GLITCH_CNT_W = 8;

  // Saturation ceiling and unit increment for the glitch counter.
  localparam logic [GLITCH_CNT_W-1:0] GLITCH_CNT_MAX = '1;
  localparam logic [GLITCH_CNT_W-1:0] GLITCH_CNT_ONE = GLITCH_CNT_W'(1);

  // True in the resting states, where the delivered level matches the input.
  function automatic logic is_idle(input deb_state_t s);
    return (s == IDLE_LOW) || (s == IDLE_HIGH);
  endfunction

  // Resting state that corresponds to a given delivered level.
  function automatic deb_state_t idle_for(input logic level);
    return level ? IDLE_HIGH : IDLE_LOW;
  endfunction

  // Qualifying state entered when the input starts to differ from a level.
  function automatic deb_state_t check_from(input logic level);
    return level ? CHECK_LOW : CHECK_HIGH;
  endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchroniser bringing one asynchronous bit into the clk domain.
// Latency: STAGES cycles from capture in stage 1 to appearance on q.
// Backpressure: none; samples every cycle.
module bit_synchronizer #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // Shift the raw bit through the chain; reset clears every stage to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/sig_a_debouncer.sv
// Debounces sig_a_raw: commits a new level after STABLE_CYCLES agreeing samples.
// Latency: SYNC_STAGES + STABLE_CYCLES cycles from raw capture to committed edge.
// Backpressure: none; input sampled every cycle, outputs are registered levels/pulses.
module sig_a_debouncer
  import sig_a_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sig_a_raw,
  output logic                    sig_a,
  output logic                    stable,
  output logic                    rise_pulse,
  output logic                    fall_pulse,
  output logic [GLITCH_CNT_W-1:0] glitch_cnt
);

  // cnt == CNT_LAST means this agreeing sample is the STABLE_CYCLES-th one.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  // With a single required sample there is nothing to qualify: commit from idle.
  localparam bit DIRECT_COMMIT = (STABLE_CYCLES == 1);

  logic                    sync;
  logic                    differs;
  logic                    commit;

  deb_state_t              state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    sig_a_q, sig_a_d;
  logic                    stable_q, stable_d;
  logic                    rise_q, rise_d;
  logic                    fall_q, fall_d;
  logic [GLITCH_CNT_W-1:0] glitch_q, glitch_d;

  bit_synchronizer #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst),
    .d     (sig_a_raw),
    .q     (sync)
  );

  assign differs = (sync != sig_a_q);

  // Next-state, counter, commit and glitch accounting.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sig_a_d  = sig_a_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    glitch_d = glitch_q;
    commit   = 1'b0;

    case (state_q)
      IDLE_LOW, IDLE_HIGH: begin
        if (differs) begin
          if (DIRECT_COMMIT) begin
            commit = 1'b1;
          end else begin
            state_d = check_from(sig_a_q);
            cnt_d   = CNT_ONE;
          end
        end
      end

      CHECK_HIGH, CHECK_LOW: begin
        if (differs) begin
          if (cnt_q == CNT_LAST) begin
            commit = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else begin
          // Input fell back before qualifying: abandon and record the glitch.
          state_d = idle_for(sig_a_q);
          cnt_d   = '0;
          if (glitch_q != GLITCH_CNT_MAX) begin
            glitch_d = glitch_q + GLITCH_CNT_ONE;
          end
        end
      end

      default: begin
        state_d = idle_for(sig_a_q);
        cnt_d   = '0;
      end
    endcase

    // A commit flips the level and lands in the resting state of the new level,
    // so the pulse and the level change are registered on the same edge.
    if (commit) begin
      sig_a_d = ~sig_a_q;
      state_d = idle_for(~sig_a_q);
      cnt_d   = '0;
      rise_d  = ~sig_a_q;
      fall_d  = sig_a_q;
    end
  end

  // Stability flag tracks the state being entered, so it is already high
  // on the edge that presents a commit.
  always_comb begin
    stable_d = is_idle(state_d);
  end

  // FSM state and qualification counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE_LOW;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Registered outputs: level, stability flag, edge pulses, glitch count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sig_a_q  <= 1'b0;
      stable_q <= 1'b1;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      glitch_q <= '0;
    end else begin
      sig_a_q  <= sig_a_d;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      glitch_q <= glitch_d;
    end
  end

  assign sig_a      = sig_a_q;
  assign stable     = stable_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign glitch_cnt = glitch_q;

endmodule

// File: tb/tb_sig_a_debouncer.sv
// Self-checking bench for sig_a_debouncer (default build and STABLE_CYCLES=1 build).
// Latency: n/a.
// Backpressure: n/a.
module tb_sig_a_debouncer;

  typedef struct {
    bit rise;
    int edge_no;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       raw0, raw1;
  logic       sig_a0, stable0, rise0, fall0;
  logic       sig_a1, stable1, rise1, fall1;
  logic [7:0] glitch0, glitch1;

  int  cyc = 0;
  int  n_tests = 0;
  int  n_fail = 0;
  ev_t q0[$];
  ev_t q1[$];

  logic prev_stable0 = 1'b1;
  logic prev_sig_a0  = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sig_a_debouncer u_dut (
    .clk        (clk),
    .rst        (rst),
    .sig_a_raw  (raw0),
    .sig_a      (sig_a0),
    .stable     (stable0),
    .rise_pulse (rise0),
    .fall_pulse (fall0),
    .glitch_cnt (glitch0)
  );

  sig_a_debouncer #(
    .STABLE_CYCLES (1)
  ) u_dut_sc1 (
    .clk        (clk),
    .rst        (rst),
    .sig_a_raw  (raw1),
    .sig_a      (sig_a1),
    .stable     (stable1),
    .rise_pulse (rise1),
    .fall_pulse (fall1),
    .glitch_cnt (glitch1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d (edge %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Default-build monitor: pops expected pulses, checks level/stability rules.
  always @(negedge clk) begin
    if (rst) begin
      if (rise0 || fall0) begin
        if (q0.size() == 0) begin
          chk("d0_unexpected_pulse", {30'd0, rise0, fall0}, 0);
        end else begin
          ev_t ev;
          ev = q0.pop_front();
          chk("d0_pulse_kind", rise0, ev.rise);
          chk("d0_pulse_edge", cyc, ev.edge_no);
        end
      end
      chk("d0_pulse_exclusive", rise0 & fall0, 0);
      if (prev_stable0) chk("d0_stable_hold", sig_a0, prev_sig_a0);
      if (sig_a0 != prev_sig_a0) chk("d0_change_has_pulse", rise0 | fall0, 1);
    end
    prev_stable0 = stable0;
    prev_sig_a0  = sig_a0;
  end

  // STABLE_CYCLES=1 monitor: pulses against scoreboard, stable never drops.
  always @(negedge clk) begin
    if (rst) begin
      if (rise1 || fall1) begin
        if (q1.size() == 0) begin
          chk("d1_unexpected_pulse", {30'd0, rise1, fall1}, 0);
        end else begin
          ev_t ev;
          ev = q1.pop_front();
          chk("d1_pulse_kind", rise1, ev.rise);
          chk("d1_pulse_edge", cyc, ev.edge_no);
        end
      end
      chk("d1_stable_high", stable1, 1);
    end
  end

  initial begin
    int k;
    int lows;
    rst  = 1'b0;
    raw0 = 1'b0;
    raw1 = 1'b0;

    // Reset values
    tick(3);
    chk("rst_sig_a", sig_a0, 0);
    chk("rst_stable", stable0, 1);
    chk("rst_rise", rise0, 0);
    chk("rst_fall", fall0, 0);
    chk("rst_glitch", glitch0, 0);
    rst = 1'b1;

    // 1: quiet input
    for (int i = 0; i < 20; i++) begin
      tick(1);
      chk("t1_stable", stable0, 1);
      chk("t1_sig_a", sig_a0, 0);
    end
    chk("t1_glitch", glitch0, 0);

    // 3: two-cycle glitch, then saturation
    lows = 0;
    raw0 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      if (i == 1) raw0 = 1'b0;
      if (!stable0) lows++;
    end
    chk("t3_stable_low_cycles", lows, 2);
    chk("t3_glitch_first", glitch0, 1);
    chk("t3_sig_a", sig_a0, 0);
    for (int i = 2; i <= 300; i++) begin
      raw0 = 1'b1;
      tick(2);
      raw0 = 1'b0;
      tick(4);
      if (i == 254) chk("t3_glitch_254", glitch0, 254);
    end
    chk("t3_glitch_sat", glitch0, 255);
    chk("t3_sig_a_after", sig_a0, 0);

    // 2: qualified rise
    k = cyc;
    raw0 = 1'b1;
    q0.push_back('{1'b1, k + 6});
    tick(2);
    chk("t2_stable_pre", stable0, 1);
    tick(1);
    chk("t2_stable_first_low", stable0, 0);
    tick(2);
    chk("t2_stable_last_low", stable0, 0);
    chk("t2_sig_a_pre", sig_a0, 0);
    tick(1);
    chk("t2_stable_commit", stable0, 1);
    chk("t2_sig_a_commit", sig_a0, 1);
    chk("t2_rise_commit", rise0, 1);
    tick(1);
    chk("t2_rise_after", rise0, 0);
    tick(3);

    // 4: qualified fall
    k = cyc;
    raw0 = 1'b0;
    q0.push_back('{1'b0, k + 6});
    tick(5);
    chk("t4_sig_a_pre", sig_a0, 1);
    tick(1);
    chk("t4_sig_a_commit", sig_a0, 0);
    chk("t4_fall_commit", fall0, 1);
    tick(1);
    chk("t4_fall_after", fall0, 0);
    chk("t4_stable_after", stable0, 1);
    tick(3);

    // 5: reset in the middle of CHECK_HIGH
    k = cyc;
    raw0 = 1'b1;
    tick(4);
    chk("t5_in_check", stable0, 0);
    rst = 1'b0;
    #1;
    chk("t5_rst_sig_a", sig_a0, 0);
    chk("t5_rst_stable", stable0, 1);
    chk("t5_rst_glitch", glitch0, 0);
    chk("t5_rst_rise", rise0, 0);
    tick(2);
    rst = 1'b1;
    k = cyc;
    q0.push_back('{1'b1, k + 6});
    tick(5);
    chk("t5_sig_a_pre", sig_a0, 0);
    tick(1);
    chk("t5_sig_a_commit", sig_a0, 1);
    chk("t5_rise_commit", rise0, 1);
    chk("t5_glitch_not_counted", glitch0, 0);
    tick(3);

    // 6: STABLE_CYCLES=1 build, toggle every 3 cycles
    for (int t = 0; t < 8; t++) begin
      k = cyc;
      raw1 = ~raw1;
      q1.push_back('{raw1, k + 3});
      tick(3);
    end
    tick(1);
    chk("t6_sig_a_final", sig_a1, 0);
    chk("t6_glitch", glitch1, 0);

    tick(10);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
